// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared AXI interconnect response codes, helpers and R-router state encoding
package axi_ic_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_BURST = 2'd1,
    R_DRAIN = 2'd2
  } r_state_e;

endpackage

// File: rtl/axi_r_skid.sv
// axi_r_skid: 2-entry full-throughput register slice; ready depends only on the skid entry
module axi_r_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic         fire, acc;

  assign fire      = out_valid_q & out_ready;
  assign acc       = in_valid & ~skid_valid_q;
  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Refill the output from the skid first so ordering holds; new beats bypass to the output when it frees up
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (fire && skid_valid_q) begin
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (acc && (!out_valid_q || fire)) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Both entries are emptied by reset so no stale beat survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/axi_r_router.sv
// axi_r_router: routes one slave R stream to N_MST master ports by the RID index bits, locked per burst
module axi_r_router
  import axi_ic_pkg::*;
#(
  parameter int N_MST  = 6,
  parameter int IDX_W  = 3,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int RESP_W = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [IDX_W+ID_W-1:0]    s_rid,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic [RESP_W-1:0]        s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  output logic [N_MST*ID_W-1:0]    m_rid,
  output logic [N_MST*DATA_W-1:0]  m_rdata,
  output logic [N_MST*RESP_W-1:0]  m_rresp,
  output logic [N_MST-1:0]         m_rlast,
  output logic [N_MST-1:0]         m_rvalid,
  input  logic [N_MST-1:0]         m_rready,
  output logic                     burst_active,
  output logic                     err_idx,
  output logic                     err_lock,
  output logic [7:0]               err_cnt
);

  localparam int PW = IDX_W + ID_W + DATA_W + RESP_W + 1;

  r_state_e          state_q, state_d;
  logic [IDX_W-1:0]  lock_q, lock_d, idx, dst, out_dst;
  logic              err_idx_q, err_idx_d, err_lock_q, err_lock_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              acc, route, idx_ok, in_ready, out_valid, out_fire, out_last;
  logic [PW-1:0]     out_pl;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;
  logic [RESP_W-1:0] out_resp;

  assign idx          = s_rid[IDX_W+ID_W-1 -: IDX_W];
  assign idx_ok       = {1'b0, idx} < (IDX_W+1)'(N_MST);
  assign s_rready     = ARESETN & in_ready;
  assign acc          = s_rvalid & s_rready;
  assign out_fire     = |(m_rvalid & m_rready);
  assign burst_active = state_q != R_IDLE;
  assign err_idx      = err_idx_q;
  assign err_lock     = err_lock_q;
  assign err_cnt      = err_cnt_q;
  assign {out_dst, out_id, out_data, out_resp, out_last} = out_pl;

  axi_r_skid #(.W(PW)) u_skid (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .in_valid  (route),
    .in_ready  (in_ready),
    .in_data   ({dst, s_rid[ID_W-1:0], s_rdata, s_rresp, s_rlast}),
    .out_valid (out_valid),
    .out_ready (out_fire),
    .out_data  (out_pl)
  );

  // Burst FSM: pick the destination on the first beat, hold it until RLAST, drop bursts with a bad index
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    dst        = lock_q;
    route      = 1'b0;
    err_idx_d  = 1'b0;
    err_lock_d = 1'b0;
    if (acc) begin
      case (state_q)
        R_IDLE: begin
          route     = idx_ok;
          dst       = idx;
          lock_d    = idx_ok ? idx : lock_q;
          err_idx_d = ~idx_ok;
          state_d   = s_rlast ? R_IDLE : (idx_ok ? R_BURST : R_DRAIN);
        end
        R_BURST: begin
          route      = 1'b1;
          err_lock_d = idx != lock_q;
          state_d    = s_rlast ? R_IDLE : R_BURST;
        end
        default: state_d = s_rlast ? R_IDLE : R_DRAIN;
      endcase
    end
    err_cnt_d = ((err_idx_d || err_lock_d) && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // FSM state, burst lock and registered error outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= R_IDLE;
      lock_q     <= '0;
      err_idx_q  <= 1'b0;
      err_lock_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      err_idx_q  <= err_idx_d;
      err_lock_q <= err_lock_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Fan the output register out to the selected lane; every other lane stays at zero
  always_comb begin
    m_rvalid = '0;
    m_rid    = '0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = '0;
    for (int k = 0; k < N_MST; k++) begin
      if (out_valid && out_dst == IDX_W'(k)) begin
        m_rvalid[k]                  = 1'b1;
        m_rid[k*ID_W +: ID_W]        = out_id;
        m_rdata[k*DATA_W +: DATA_W]  = out_data;
        m_rresp[k*RESP_W +: RESP_W]  = out_resp;
        m_rlast[k]                   = out_last;
      end
    end
  end

endmodule

// File: doc/axi_r_router.md
Name: axi_r_router

Overview:
- Next-generation read-data (R) channel router for the AXI interconnect, replacing the fixed 6-way combinational demux.
- One slave-side R stream is routed to one of N_MST master ports using a master index carried in the upper RID bits.
- Full AXI valid/ready handshaking with a registered, full-throughput skid stage.
- Destination is locked per burst until RLAST; beats with an invalid index are drained and counted as errors.

Parameters:
N_MST, 6, number of master ports (2..8)
IDX_W, 3, master-index width; must satisfy 2**IDX_W >= N_MST
ID_W, 4, master-side RID width
DATA_W, 32, RDATA width
RESP_W, 2, RRESP width

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous assert, active-low
s_rid  in  IDX_W+ID_W  slave RID; upper IDX_W bits = destination master index
s_rdata  in  DATA_W  slave read data
s_rresp  in  RESP_W  slave read response
s_rlast  in  1  last beat of burst
s_rvalid  in  1  slave beat valid
s_rready  out  1  router can accept a beat
m_rid  out  N_MST*ID_W  per-master RID, lane k = bits [k*ID_W +: ID_W]
m_rdata  out  N_MST*DATA_W  per-master data lanes
m_rresp  out  N_MST*RESP_W  per-master response lanes
m_rlast  out  N_MST  per-master RLAST
m_rvalid  out  N_MST  per-master valid, at most one bit set
m_rready  in  N_MST  per-master ready
burst_active  out  1  FSM in BURST or DRAIN
err_idx  out  1  one-cycle pulse: beat accepted with index >= N_MST
err_lock  out  1  one-cycle pulse: mid-burst beat index differs from locked index
err_cnt  out  8  saturating count of err_idx plus err_lock events

Behaviour:
- Clocking and reset: one clock, ACLK. Reset is asynchronous and active-low on ARESETN.
- Reset values: all outputs are 0, including s_rready. The FSM enters IDLE and both buffer entries are emptied.
- Reset mid-operation: buffered beats are discarded and the burst lock is cleared. No m_rvalid is asserted until a new beat is accepted after reset is released.
- Accept condition: a beat is accepted when s_rvalid && s_rready. s_rready = ~skid_valid, a registered term, so s_rready is 1 in the first cycle after reset release.
- Latency: an accepted beat presents on m_rvalid[dst] in the next cycle. Sustained throughput is 1 beat/cycle while the destination's m_rready stays high.
- Output register: out_valid, out_dst, out_id, out_data, out_resp, out_last.
  - m_rvalid[out_dst] = out_valid. The beat fires on m_rready[out_dst].
  - Non-selected lanes drive id, data, resp and last as 0. The selected lane drives zeros whenever out_valid = 0.
- Skid register:
  - An accepted routed beat loads out_* when the output is empty or fires in the same cycle; otherwise it loads skid_*.
  - When the output fires with skid_valid = 1, the skid beat moves to out_* and skid_valid clears.
  - Ordering is strictly preserved.
- FSM, evaluated only on accepted beats. idx = s_rid[IDX_W+ID_W-1 -: IDX_W].
  - IDLE, idx < N_MST: route to idx and set lock = idx. If !s_rlast, go to BURST.
  - IDLE, idx >= N_MST: pulse err_idx and drop the beat (it never enters a buffer). If !s_rlast, go to DRAIN.
  - BURST: route to lock regardless of idx. If idx != lock, pulse err_lock. On s_rlast, go to IDLE.
  - DRAIN: drop the beat. On s_rlast, go to IDLE. No further err_idx pulses within the drained burst.
- Single-beat bursts: a beat with s_rlast = 1 in IDLE returns to IDLE in the same transition.
- Dropped beats never stall: s_rready still depends only on skid_valid.
- m_rid lane: carries s_rid[ID_W-1:0]; the index bits are stripped.
- err_cnt: increments by the number of error pulses in a cycle (at most 1) and saturates at 255.
- Back-to-back bursts to different masters: allowed with no bubble. The next burst's first beat may be accepted in the cycle after the previous RLAST is accepted.

Decomposition:
- Shared package axi_ic_pkg holds:
  - RESP codes OKAY/EXOKAY/SLVERR/DECERR.
  - A clog2 helper.
  - The r_router FSM state encoding (IDLE=2'd0, BURST=2'd1, DRAIN=2'd2).
- Natural sub-module: axi_r_skid, a 2-entry register slice carrying {dst, id, data, resp, last} with valid/ready.
- axi_r_router wraps axi_r_skid with the FSM, index decode and lane fan-out.

Test Plan:
1. Reset release, then a 4-beat burst with s_rid=7'b010_0011 and rdata 1..4, m_rready[2]=1 → m_rvalid[2] high cycles 1..4 after acceptance, m_rid lane2=4'h3, m_rlast[2] on beat 4 only, all other lanes 0.
2. Burst to master 1 with m_rready[1] held low 3 cycles mid-burst → s_rready drops after the skid fills, no beat is lost or reordered, and data 1..8 arrives in order.
3. Burst with index 6 (N_MST=6), 3 beats → err_idx pulses once, all 3 beats accepted with s_rready=1, no m_rvalid, err_cnt=1, FSM back in IDLE after the last beat.
4. Burst locked to master 0 whose beat 2 carries index 3 → all beats go to m_rvalid[0], err_lock pulses once, err_cnt increments.
5. Back-to-back single-beat bursts to masters 5, 0, 4 with all ready → one beat/cycle on m_rvalid[5], [0], [4] in consecutive cycles.
6. ARESETN low mid-burst with skid full → all outputs 0 immediately (asynchronously), burst_active=0, err_cnt=0, and no stale beat after release.
